// File: rtl/nyq_pkg.sv
// Shared definitions for the polyphase Nyquist decimator: control word
// layout, accumulator sizing and the output round/saturate helper.
package nyq_pkg;

    localparam int SHIFT_LSB = 0;
    localparam int SHIFT_MSB = 5;
    localparam int EN_BIT    = 8;

    // Formatting runs at a fixed wide width so one helper serves every
    // parameterisation; callers sign-extend into it and slice the result.
    localparam int FMT_W = 128;

    typedef logic signed [FMT_W-1:0] wide_t;

    typedef struct packed {
        logic [FMT_W-1:0] value;
        logic             sat;
    } fmt_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int acc_width(input int in_w, input int coef_w, input int n);
        return in_w + coef_w + clog2(n);
    endfunction

    // Round half up by 2^shift, then clip into a signed out_w-bit range.
    function automatic fmt_t round_sat(input wide_t r,
                                       input logic [SHIFT_MSB-SHIFT_LSB:0] shift,
                                       input int out_w);
        wide_t half;
        wide_t rnd;
        wide_t hi;
        wide_t lo;
        fmt_t  f;
        rnd = r;
        if (shift != '0) begin
            half = wide_t'(1) <<< (shift - 1'b1);
            rnd  = (r + half) >>> shift;
        end
        hi = (wide_t'(1) <<< (out_w - 1)) - wide_t'(1);
        lo = ~hi;
        if (rnd > hi) begin
            f.value = hi;
            f.sat   = 1'b1;
        end else if (rnd < lo) begin
            f.value = lo;
            f.sat   = 1'b1;
        end else begin
            f.value = rnd;
            f.sat   = 1'b0;
        end
        return f;
    endfunction

endpackage

// File: rtl/nyq_poly_decim_if.sv
// Parameter write port, sample input and decimated output of the decimator.
interface nyq_poly_decim_if #(
    parameter int ADDR_WIDTH = 9,
    parameter int MEM_WIDTH  = 32,
    parameter int IN_WIDTH   = 24,
    parameter int OUT_WIDTH  = 24
);
    logic                  WrEn_SI;
    logic [ADDR_WIDTH-1:0] Addr_DI;
    logic [MEM_WIDTH-1:0]  PAR_In_DI;
    logic [IN_WIDTH-1:0]   NYQ_In_DI;
    logic                  NYQ_InValid_SI;
    logic [OUT_WIDTH-1:0]  NYQ_Out_DO;
    logic                  NYQ_Valid_DO;
    logic                  NYQ_Sat_DO;

    modport master (
        output WrEn_SI, Addr_DI, PAR_In_DI, NYQ_In_DI, NYQ_InValid_SI,
        input  NYQ_Out_DO, NYQ_Valid_DO, NYQ_Sat_DO
    );

    modport slave (
        input  WrEn_SI, Addr_DI, PAR_In_DI, NYQ_In_DI, NYQ_InValid_SI,
        output NYQ_Out_DO, NYQ_Valid_DO, NYQ_Sat_DO
    );
endinterface

// File: rtl/nyq_mac_lane.sv
// One MAC lane: picks this lane's coefficient for the current phase and
// accumulates coefficient*sample over a block, restarting at phase 0.
module nyq_mac_lane #(
    parameter int DECIM      = 8,
    parameter int IN_WIDTH   = 24,
    parameter int COEF_WIDTH = 24,
    parameter int ACC_WIDTH  = 53,
    parameter int PH_WIDTH   = 3
) (
    input  logic                         Clk_CI,
    input  logic                         Rst_RBI,
    input  logic signed [COEF_WIDTH-1:0] coef [DECIM],
    input  logic        [PH_WIDTH-1:0]   phase,
    input  logic signed [IN_WIDTH-1:0]   sample,
    input  logic                         accept,
    input  logic                         flush,
    output logic signed [ACC_WIDTH-1:0]  acc_next
);
    logic signed [ACC_WIDTH-1:0]           acc;
    logic signed [COEF_WIDTH-1:0]          coef_sel;
    logic signed [IN_WIDTH+COEF_WIDTH-1:0] prod;

    // Next accumulator value: phase 0 starts a fresh block sum.
    always_comb begin
        coef_sel = coef[phase];
        prod     = sample * coef_sel;
        acc_next = ACC_WIDTH'(prod) + ((phase == '0) ? '0 : acc);
    end

    // Accumulator register; a control write clears it, otherwise it only
    // moves on accepted samples.
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            acc <= '0;
        end else if (flush) begin
            acc <= '0;
        end else if (accept) begin
            acc <= acc_next;
        end
    end
endmodule

// File: rtl/nyq_poly_decim.sv
// Polyphase Nyquist decimator: NUM_MAC lanes each own DECIM taps; lane sums
// of successive blocks are combined through a delay chain so every output
// covers the full N-tap response.
module nyq_poly_decim
    import nyq_pkg::*;
#(
    parameter int ADDR_WIDTH = 9,
    parameter int MEM_WIDTH  = 32,
    parameter int DECIM      = 8,
    parameter int NUM_MAC    = 4,
    parameter int IN_WIDTH   = 24,
    parameter int COEF_WIDTH = 24,
    parameter int OUT_WIDTH  = 24
) (
    input logic             Clk_CI,
    input logic             Rst_RBI,
    nyq_poly_decim_if.slave bus
);
    localparam int N         = DECIM * NUM_MAC;
    localparam int ACC_WIDTH = acc_width(IN_WIDTH, COEF_WIDTH, N);
    localparam int PH_WIDTH  = (DECIM > 1) ? clog2(DECIM) : 1;
    localparam logic [ADDR_WIDTH-1:0] CTRL_ADDR = ADDR_WIDTH'(N);
    localparam logic [PH_WIDTH-1:0]   LAST_PH   = PH_WIDTH'(DECIM - 1);

    logic signed [COEF_WIDTH-1:0]      coef_mem [N];
    logic [SHIFT_MSB-SHIFT_LSB:0]      shift;
    logic                              en;
    logic [PH_WIDTH-1:0]               phase;
    logic                              ctrl_wr;
    logic                              accept;
    logic                              last;
    logic signed [ACC_WIDTH-1:0]       acc_next [NUM_MAC];
    logic signed [ACC_WIDTH-1:0]       result;
    fmt_t                              fmt;
    logic signed [OUT_WIDTH-1:0]       out;
    logic                              sat;
    logic                              vld;
    logic                              unused_bits;

    // Acceptance qualification; a control write always wins over a sample.
    always_comb begin
        ctrl_wr = bus.WrEn_SI && (bus.Addr_DI == CTRL_ADDR);
        accept  = bus.NYQ_InValid_SI && en && !ctrl_wr;
        last    = accept && (phase == LAST_PH);
    end

    // Parameter memory: coefficients plus control word, unmapped writes dropped.
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            for (int a = 0; a < N; a++) coef_mem[a] <= '0;
            shift <= '0;
            en    <= 1'b0;
        end else if (bus.WrEn_SI) begin
            for (int a = 0; a < N; a++) begin
                if (bus.Addr_DI == ADDR_WIDTH'(a)) coef_mem[a] <= bus.PAR_In_DI[COEF_WIDTH-1:0];
            end
            if (ctrl_wr) begin
                shift <= bus.PAR_In_DI[SHIFT_MSB:SHIFT_LSB];
                en    <= bus.PAR_In_DI[EN_BIT];
            end
        end
    end

    // Phase counter over one block of DECIM accepted samples.
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            phase <= '0;
        end else if (ctrl_wr) begin
            phase <= '0;
        end else if (accept) begin
            phase <= (phase == LAST_PH) ? '0 : phase + 1'b1;
        end
    end

    for (genvar j = 0; j < NUM_MAC; j++) begin : g_lane
        logic signed [COEF_WIDTH-1:0] lane_coef [DECIM];

        // Lane j owns taps j*DECIM .. j*DECIM+DECIM-1.
        always_comb begin
            for (int p = 0; p < DECIM; p++) lane_coef[p] = coef_mem[p + j * DECIM];
        end

        nyq_mac_lane #(
            .DECIM     (DECIM),
            .IN_WIDTH  (IN_WIDTH),
            .COEF_WIDTH(COEF_WIDTH),
            .ACC_WIDTH (ACC_WIDTH),
            .PH_WIDTH  (PH_WIDTH)
        ) u_lane (
            .Clk_CI  (Clk_CI),
            .Rst_RBI (Rst_RBI),
            .coef    (lane_coef),
            .phase   (phase),
            .sample  (bus.NYQ_In_DI),
            .accept  (accept),
            .flush   (ctrl_wr),
            .acc_next(acc_next[j])
        );
    end

    if (NUM_MAC > 1) begin : g_chain
        logic signed [ACC_WIDTH-1:0] chain [NUM_MAC-1];

        // Delay chain: chain[j] carries lanes 0..j summed across staggered blocks.
        always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
            if (!Rst_RBI) begin
                for (int j = 0; j < NUM_MAC - 1; j++) chain[j] <= '0;
            end else if (ctrl_wr) begin
                for (int j = 0; j < NUM_MAC - 1; j++) chain[j] <= '0;
            end else if (last) begin
                chain[0] <= acc_next[0];
                for (int j = 1; j < NUM_MAC - 1; j++) chain[j] <= acc_next[j] + chain[j-1];
            end
        end

        assign result = acc_next[NUM_MAC-1] + chain[NUM_MAC-2];
    end else begin : g_single
        assign result = acc_next[0];
    end

    // Output shift, rounding and clipping of the completed block sum.
    always_comb begin
        fmt = round_sat(wide_t'(result), shift, OUT_WIDTH);
    end

    // Output register loads on block completion; valid follows one cycle later.
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            out <= '0;
            sat <= 1'b0;
            vld <= 1'b0;
        end else if (ctrl_wr) begin
            out <= '0;
            sat <= 1'b0;
            vld <= 1'b0;
        end else begin
            vld <= last;
            if (last) begin
                out <= fmt.value[OUT_WIDTH-1:0];
                sat <= fmt.sat;
            end
        end
    end

    assign bus.NYQ_Out_DO   = out;
    assign bus.NYQ_Sat_DO   = sat;
    assign bus.NYQ_Valid_DO = vld;

    // Upper formatter bits and unmapped write-data bits carry no information.
    assign unused_bits = ^{fmt.value, bus.PAR_In_DI};
endmodule

// File: doc/nyq_poly_decim.md
# nyq_poly_decim

Parametrised polyphase Nyquist decimation filter. It is the successor of the fixed 8×4 Nyquist block. It low-pass filters a signed sample stream and emits one output per DECIM accepted inputs. Additions over the previous generation:
- input valid qualification
- run-time output shift, rounding and saturation
- an enable/flush control word

It sits between the front-end sample source and downstream decimated-rate blocks, and is programmed through the common parameter-memory write port.

## Interface
- ADDR_WIDTH, 9, parameter address width
- MEM_WIDTH, 32, parameter word width
- DECIM, 8, decimation factor (≥1)
- NUM_MAC, 4, MAC lanes; filter length N = DECIM·NUM_MAC; N+1 ≤ 2^ADDR_WIDTH
- IN_WIDTH, 24, signed input width
- COEF_WIDTH, 24, signed coefficient width (≤ MEM_WIDTH, taken from word LSBs)
- OUT_WIDTH, 24, signed output width
- Clk_CI  in  1  clock
- Rst_RBI  in  1  reset, asynchronous, active-low
- WrEn_SI  in  1  parameter write enable, active high
- Addr_DI  in  ADDR_WIDTH  parameter address
- PAR_In_DI  in  MEM_WIDTH  parameter write data
- NYQ_In_DI  in  IN_WIDTH  signed input sample
- NYQ_InValid_SI  in  1  input sample valid
- NYQ_Out_DO  out  OUT_WIDTH  signed decimated output
- NYQ_Valid_DO  out  1  one-cycle pulse, NYQ_Out_DO new
- NYQ_Sat_DO  out  1  saturation flag for current NYQ_Out_DO

## Operation

**Memory map**
- Addresses 0..N-1 hold coefficients c[a].
- Address CTRL = N holds the control word: bits [5:0] SHIFT (0..ACC_WIDTH-OUT_WIDTH); bit 8 EN.
- Other addresses: writes ignored.
- Only N+1 words are implemented, all reset to 0.

**Sample acceptance**
- A sample is accepted on a rising edge with NYQ_InValid_SI=1, EN=1, and no CTRL write in that cycle.
- Phase counter p (0..DECIM-1) advances on each accepted sample and wraps from DECIM-1 to 0. Otherwise it holds.

**Lanes**
- Lane j (0..NUM_MAC-1) computes A_j ← (p==0 ? 0 : A_j) + c[p + j·DECIM]·x.
- Full precision: ACC_WIDTH = IN_WIDTH + COEF_WIDTH + clog2(N).

**Block completion** (accepted sample with p==DECIM-1), using the lane next-values A'_j:
- Chain: T_0 ← A'_0; T_j ← A'_j + T_{j-1} for j = 1..NUM_MAC-2.
- Output: R = A'_{NUM_MAC-1} + T_{NUM_MAC-2} (R = A'_0 when NUM_MAC=1).
- Result: y[m] = Σ_j A_j[m-(NUM_MAC-1-j)], where A_j[m] = Σ_p c[p+j·DECIM]·x[m·DECIM+p].

**Output formatting**
- If SHIFT>0: R' = (R + 2^(SHIFT-1)) >>> SHIFT (round half up). Otherwise R' = R.
- Saturate R' to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]. NYQ_Sat_DO=1 when clipped.

**Control and flush**
- A CTRL write is a synchronous flush: p, A_j, T_j and pending output all clear to 0.
- EN=0: inputs ignored, all state held, no NYQ_Valid_DO.

## Timing
- Reset values: NYQ_Out_DO=0, NYQ_Valid_DO=0, NYQ_Sat_DO=0; p, A, T and all memory words = 0.
- Latency: the edge that accepts the p==DECIM-1 sample also loads NYQ_Out_DO and NYQ_Sat_DO. NYQ_Valid_DO is high for exactly the following cycle.
- NYQ_Out_DO and NYQ_Sat_DO hold until the next block completes.
- Gaps in NYQ_InValid_SI stretch the block; there is no upper bound.
- Coefficient write and accepted sample in the same cycle: the MAC uses the old coefficient; the new value applies from the next cycle.
- CTRL write and valid sample in the same cycle: the write wins, the sample is dropped, the flush is applied. The new SHIFT/EN take effect from the next cycle.
- Reset asserted mid-block: immediate clear; no partial output ever emitted.
- DECIM=1: every accepted sample completes a block.

## Structure
- Package nyq_pkg holds:
  - CTRL field positions (SHIFT_LSB/MSB, EN_BIT)
  - ACC_WIDTH derivation and clog2 function
  - round/saturate function
- Sub-module nyq_mac_lane (one per j, generate loop): coefficient select by p, multiply, clear-or-accumulate register, next-value output.
- Top level contains: memory, phase counter, chain registers, output formatting.

## Test plan
All scenarios use DECIM=8, NUM_MAC=4.
- Reset: assert Rst_RBI mid-stream → all outputs and state 0 immediately; no NYQ_Valid_DO until 8 new accepted samples.
- Impulse: c[a]=a+1, SHIFT=0, EN=1, x=1 then zeros → y = 25, 17, 9, 1, 0, each with one NYQ_Valid_DO pulse every 8 samples.
- DC with gaps: all c=1, x=1000, NYQ_InValid_SI toggling 1/0 → y = 8000, 16000, 24000, 32000, 32000…; output count = accepted/8.
- Round/saturate:
  - only c[24]=1, SHIFT=2, first x=6 → y[0]=2; with x=-6 → y[0]=-1.
  - all c=0x7FFFFF, x=0x7FFFFF, SHIFT=0 → 0x7FFFFF with Sat=1.
  - all c=0x7FFFFF, x=0x800000, SHIFT=0 → 0x800000 with Sat=1.
- Flush: accept 3 samples, write CTRL (EN=1) with valid high in the same cycle → sample dropped; the next 8 accepted samples give the same y[0] as a fresh-reset run.
- Coefficient race: write c[24]=5 in the same cycle as the block's first sample (x=1, old c[24]=1) → y[0]=1; the next block uses 5.
